tt_um_count_checker: RTL and testbench

- Receive-side companion to the team's free-running 8-bit counter tile.
- Samples an 8-bit stream on ui_in every clock and checks that each sample is the previous sample + 1, modulo 256.
- Acquires and holds lock on the sequence, counts sequence errors while locked, and reports status on uo_out/uio_out.
- Used as the loopback checker when a counter tile's uo_out is wired to this tile's ui_in.

---
 rtl/count_checker_pkg.sv | 20 ++
 rtl/count_checker_sync.sv | 23 ++
 rtl/tt_um_count_checker.sv | 133 +++++++++++++
 tb/tb_tt_um_count_checker.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/count_checker_pkg.sv
// Shared types and constants for the counter-stream checker tile.
package count_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int unsigned UIO_SEL       = 0;
    localparam int unsigned UIO_CLR       = 1;
    localparam int unsigned UIO_LOCKED    = 2;
    localparam int unsigned UIO_ERR_PULSE = 3;
    localparam int unsigned UIO_ERR_SAT   = 4;
    localparam int unsigned UIO_ACQ       = 5;

    localparam logic [7:0] UIO_OE_MASK = 8'hFC;
    localparam logic [7:0] ERR_MAX     = 8'hFF;

endpackage

// File: rtl/count_checker_sync.sv
// Two-flop input synchronizer with synchronous active-low reset.
module count_checker_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_um_count_checker.sv
// Checks that ui_in increments by one (mod 256) each clock; tracks lock and error count.
// Define COUNT_CHECKER_SYNC_EN to insert a 2-flop synchronizer on ui_in.
module tt_um_count_checker
    import count_checker_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    logic [7:0] sample;

`ifdef COUNT_CHECKER_SYNC_EN
    count_checker_sync #(.WIDTH(8)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in),
        .q     (sample)
    );
`else
    assign sample = ui_in;
`endif

    state_t     state_q, state_d;
    logic [7:0] prev_q;
    logic [3:0] run_q, run_d;
    logic [3:0] bad_q, bad_d;
    logic [7:0] err_q, err_d;
    logic       pulse_q, pulse_d;

    logic [7:0] prev_inc;
    logic [3:0] run_inc;
    logic [3:0] bad_inc;
    logic       good;
    logic       clr;

    assign prev_inc = prev_q + 8'd1;
    assign run_inc  = run_q + 4'd1;
    assign bad_inc  = bad_q + 4'd1;
    assign good     = (sample == prev_inc);
    assign clr      = uio_in[UIO_CLR];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= '0;
            run_q   <= '0;
            bad_q   <= '0;
            err_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= sample;
            run_q   <= run_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        bad_d   = bad_q;
        err_d   = err_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = ACQ;
                run_d   = '0;
            end
            ACQ: begin
                if (good) begin
                    run_d = run_inc;
                    if (run_inc == LOCK_TGT) begin
                        state_d = LOCKED;
                        bad_d   = '0;
                    end
                end else begin
                    run_d = '0;
                end
            end
            LOCKED: begin
                if (good) begin
                    bad_d = '0;
                end else begin
                    pulse_d = 1'b1;
                    bad_d   = bad_inc;
                    if (err_q != ERR_MAX)
                        err_d = err_q + 8'd1;
                    if (bad_inc == LOSS_TGT) begin
                        state_d = ACQ;
                        run_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = '0;
                bad_d   = '0;
            end
        endcase
        // Clear takes priority over a same-edge increment; the pulse still reports the error.
        if (clr)
            err_d = '0;
    end

    always_comb begin
        uio_out                = '0;
        uio_out[UIO_LOCKED]    = (state_q == LOCKED);
        uio_out[UIO_ERR_PULSE] = pulse_q;
        uio_out[UIO_ERR_SAT]   = (err_q == ERR_MAX);
        uio_out[UIO_ACQ]       = (state_q == ACQ);
    end

    assign uo_out = uio_in[UIO_SEL] ? prev_q : err_q;
    assign uio_oe = UIO_OE_MASK;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Directed self-checking bench for tt_um_count_checker (default build).
module tb_tt_um_count_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    logic [7:0]  v;

    always #5 clk = ~clk;

    tt_um_count_checker #(.LOCK_CNT(4), .LOSS_CNT(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic step(input logic [7:0] val);
        ui_in = val;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        step(8'h33);
        step(8'h34);
        total_cnt++; if (uo_out !== 8'h00) $display("FAIL reset_uo_out: got %h exp 00", uo_out); else pass_cnt++;
        total_cnt++; if (uio_out !== 8'h00) $display("FAIL reset_uio_out: got %h exp 00", uio_out); else pass_cnt++;
        total_cnt++; if (uio_oe !== 8'hFC) $display("FAIL reset_uio_oe: got %h exp FC", uio_oe); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        step(8'h00);
        total_cnt++; if (uio_out !== 8'h20) $display("FAIL lock_acq_after_s0: got uio_out %h exp 20", uio_out); else pass_cnt++;
        step(8'h01);
        step(8'h02);
        step(8'h03);
        total_cnt++; if (uio_out[2] !== 1'b0) $display("FAIL lock_early_s3: got locked %b exp 0", uio_out[2]); else pass_cnt++;
        step(8'h04);
        total_cnt++; if (uio_out !== 8'h04) $display("FAIL lock_after_s4: got uio_out %h exp 04", uio_out); else pass_cnt++;
        step(8'h05);
        total_cnt++; if (uo_out !== 8'h00) $display("FAIL lock_err_cnt: got %h exp 00", uo_out); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int unsigned bad_seen = 0;
        for (int i = 6; i <= 8'hFD; i++) begin
            step(8'(i));
            if (uio_out !== 8'h04) bad_seen++;
        end
        total_cnt++; if (bad_seen != 0) $display("FAIL ramp_hold: got %0d bad status cycles exp 0", bad_seen); else pass_cnt++;
        v = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            step(v);
            total_cnt++; if (uio_out !== 8'h04) $display("FAIL wrap_status_%0d: got uio_out %h exp 04", i, uio_out); else pass_cnt++;
            v = v + 8'd1;
        end
        total_cnt++; if (uo_out !== 8'h00) $display("FAIL wrap_err_cnt: got %h exp 00", uo_out); else pass_cnt++;
    endtask

    task automatic test_glitch();
        for (int i = 2; i <= 8'h10; i++) step(8'(i));
        step(8'h55);
        total_cnt++; if (uio_out !== 8'h0C) $display("FAIL glitch_pulse: got uio_out %h exp 0C", uio_out); else pass_cnt++;
        total_cnt++; if (uo_out !== 8'h01) $display("FAIL glitch_err_cnt: got %h exp 01", uo_out); else pass_cnt++;
        step(8'h56);
        total_cnt++; if (uio_out !== 8'h04) $display("FAIL glitch_pulse_one_cycle: got uio_out %h exp 04", uio_out); else pass_cnt++;
        step(8'h57);
        total_cnt++; if (uio_out !== 8'h04 || uo_out !== 8'h01) $display("FAIL glitch_hold: got uio_out %h uo_out %h exp 04/01", uio_out, uo_out); else pass_cnt++;
    endtask

    task automatic test_loss();
        uio_in[1] = 1'b1;
        step(8'h58);
        uio_in[1] = 1'b0;
        total_cnt++; if (uo_out !== 8'h00 || uio_out !== 8'h04) $display("FAIL loss_pre_clear: got uo_out %h uio_out %h exp 00/04", uo_out, uio_out); else pass_cnt++;
        step(8'h20);
        total_cnt++; if (uio_out !== 8'h0C || uo_out !== 8'h01) $display("FAIL loss_first_bad: got uio_out %h uo_out %h exp 0C/01", uio_out, uo_out); else pass_cnt++;
        step(8'h20);
        total_cnt++; if (uio_out !== 8'h28 || uo_out !== 8'h02) $display("FAIL loss_second_bad: got uio_out %h uo_out %h exp 28/02", uio_out, uo_out); else pass_cnt++;
        step(8'h20);
        total_cnt++; if (uio_out !== 8'h20 || uo_out !== 8'h02) $display("FAIL loss_bad_in_acq: got uio_out %h uo_out %h exp 20/02", uio_out, uo_out); else pass_cnt++;
    endtask

    task automatic test_sat_clear();
        step(8'h21);
        step(8'h22);
        step(8'h23);
        step(8'h24);
        total_cnt++; if (uio_out !== 8'h04) $display("FAIL relock: got uio_out %h exp 04", uio_out); else pass_cnt++;
        v = 8'h24;
        for (int i = 0; i < 300; i++) begin
            v = v + 8'd5;
            step(v);
            v = v + 8'd1;
            step(v);
        end
        total_cnt++; if (uo_out !== 8'hFF) $display("FAIL sat_err_cnt: got %h exp FF", uo_out); else pass_cnt++;
        total_cnt++; if (uio_out !== 8'h14) $display("FAIL sat_status: got uio_out %h exp 14", uio_out); else pass_cnt++;
        uio_in[1] = 1'b1;
        v = v + 8'd5;
        step(v);
        uio_in[1] = 1'b0;
        total_cnt++; if (uo_out !== 8'h00) $display("FAIL clr_wins_err_cnt: got %h exp 00", uo_out); else pass_cnt++;
        total_cnt++; if (uio_out !== 8'h0C) $display("FAIL clr_wins_status: got uio_out %h exp 0C", uio_out); else pass_cnt++;
    endtask

    task automatic test_sel_reset();
        v = v + 8'd1;
        step(v);
        total_cnt++; if (uio_out !== 8'h04) $display("FAIL sel_locked: got uio_out %h exp 04", uio_out); else pass_cnt++;
        uio_in[0] = 1'b1;
        #1;
        total_cnt++; if (uo_out !== v) $display("FAIL sel_sample: got %h exp %h", uo_out, v); else pass_cnt++;
        uio_in[0] = 1'b0;
        #1;
        total_cnt++; if (uo_out !== 8'h00) $display("FAIL sel_count: got %h exp 00", uo_out); else pass_cnt++;
        uio_in[0] = 1'b1;
        rst_n = 1'b0;
        step(v + 8'd1);
        total_cnt++; if (uo_out !== 8'h00) $display("FAIL midrst_uo_out: got %h exp 00", uo_out); else pass_cnt++;
        total_cnt++; if (uio_out !== 8'h00) $display("FAIL midrst_uio_out: got %h exp 00", uio_out); else pass_cnt++;
        total_cnt++; if (uio_oe !== 8'hFC) $display("FAIL midrst_uio_oe: got %h exp FC", uio_oe); else pass_cnt++;
        rst_n = 1'b1;
        step(8'h40);
        total_cnt++; if (uio_out !== 8'h20 || uo_out !== 8'h40) $display("FAIL post_rst_idle: got uio_out %h uo_out %h exp 20/40", uio_out, uo_out); else pass_cnt++;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        v      = 8'h00;
        test_reset();
        test_lock();
        test_wrap();
        test_glitch();
        test_loss();
        test_sat_clear();
        test_sel_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
